pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the write-enable and bubble/flush controls of the PC, the IF/ID register and the ID/EXE register. It generates the EXE/MEM-to-ID forwarding selects. It also schedules the shared multi-cycle multiply/divide unit (MDU), stalling ID while that unit is busy.

Parameters:
MUL_CYCLES, 4, MDU latency for mult/multu in cycles (>=1).
DIV_CYCLES, 32, MDU latency for div/divu in cycles (>=1).
CNT_W, 6, busy-counter width; must hold max(MUL_CYCLES,DIV_CYCLES)-1.

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-low reset.
id_rs  in  5  rs field of the instruction in ID.
id_rt  in  5  rt field of the instruction in ID.
id_rs_used  in  1  ID instruction reads rs.
id_rt_used  in  1  ID instruction reads rt.
id_mdu_op  in  2  00 none, 01 mult, 10 div, 11 HI/LO read or write.
id_branch_taken  in  1  ID resolved a taken branch or jump.
exe_rf_we  in  1  EXE-stage regfile write enable.
exe_rf_waddr  in  5  EXE-stage destination register.
exe_is_load  in  1  EXE instruction is a load, so its data is not ready until MEM.
mem_rf_we  in  1  MEM-stage regfile write enable.
mem_rf_waddr  in  5  MEM-stage destination register.
pc_we  out  1  PC update enable.
iireg_we  out  1  IF/ID register write enable.
iireg_flush  out  1  load a zero (nop) instruction into IF/ID.
iereg_we  out  1  ID/EXE register write enable.
iereg_bubble  out  1  load nop controls into ID/EXE (rf_we=0, dmem_we=0).
fwd_rs_sel  out  2  00 regfile, 01 EXE result, 10 MEM result.
fwd_rt_sel  out  2  same encoding, for rt.
mdu_start  out  1  one-cycle MDU launch pulse.
mdu_is_div  out  1  qualifies mdu_start: 1 = divide.
mdu_busy  out  1  MDU operation in flight.
stall_count  out  32  saturating count of stall cycles.

Behaviour:
- State: FSM {RUN, BUSY}, CNT_W-bit down-counter cnt, 32-bit stall_count. All registers clear asynchronously while reset=0.
- While reset=0, every output is 0 and every select is 00; state=RUN, cnt=0, stall_count=0. Reset in mid-MDU operation aborts it: the controller comes out of reset in RUN, with no start pulse replayed.
- Hazard terms (combinational):
  - rs_hit_X = id_rs_used & X_rf_we & (X_rf_waddr!=0) & (X_rf_waddr==id_rs), for X = exe or mem; rt_hit_X is formed the same way.
  - load_use = exe_is_load & (rs_hit_exe | rt_hit_exe).
  - mdu_hazard = (state==BUSY) & (id_mdu_op!=00).
  - stall = load_use | mdu_hazard.
- Stall outputs: pc_we=~stall, iireg_we=~stall, iereg_we=1, iereg_bubble=stall.
- Flush: iireg_flush = id_branch_taken & ~stall. A stalled branch is re-evaluated next cycle.
- Forwarding: fwd_rs_sel=01 if rs_hit_exe & ~exe_is_load; else 10 if rs_hit_mem; else 00. EXE has priority over MEM, and register 0 is never forwarded. fwd_rt_sel follows the same rule on rt.
- Launch: mdu_start = (state==RUN) & ~load_use & (id_mdu_op==01 | id_mdu_op==10). mdu_is_div = (id_mdu_op==10) when mdu_start=1, else 0.
- RUN -> BUSY on mdu_start. On that edge cnt loads (MUL_CYCLES-1) or (DIV_CYCLES-1).
- BUSY: cnt decrements each cycle. When cnt==0 the state returns to RUN at the next edge, so BUSY lasts exactly the latency L in cycles.
- mdu_busy = (state==BUSY). An MDU op in ID during the last BUSY cycle still stalls and launches in the first RUN cycle.
- Latency of 1: RUN -> BUSY (cnt=0) -> RUN, giving one busy cycle.
- Non-MDU instructions proceed normally during BUSY; there is no stall for them.
- stall_count increments on every clk edge where stall=1, saturating at 0xFFFFFFFF.
- Simultaneous load_use and MDU op in ID in RUN: stall applies, mdu_start=0, and the launch occurs once load_use clears.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs -> all outputs 0. Release reset -> pc_we=1, iireg_we=1, iereg_we=1, stall_count=0.
- Load-use: exe_is_load=1, exe_rf_we=1, exe_rf_waddr=5, id_rs=5, id_rs_used=1 -> pc_we=0, iireg_we=0, iereg_bubble=1 for one cycle, and stall_count becomes 1. Then drop the load in EXE -> stall clears.
- Forwarding priority: exe and mem both write reg 8, id_rt=8, exe_is_load=0 -> fwd_rt_sel=01. With exe_rf_we=0 -> 10. With the destination = reg 0 -> 00.
- Divide sequencing: id_mdu_op=10 in RUN -> mdu_start=1, mdu_is_div=1 for one cycle, then mdu_busy=1 for exactly 32 cycles. A second mult in ID throughout that window sees pc_we=0, and its mdu_start is issued the cycle mdu_busy falls.
- Branch flush: id_branch_taken=1 with no hazard -> iireg_flush=1. Same cycle with load_use=1 -> iireg_flush=0, iereg_bubble=1.
- Async reset mid-divide: pull reset low at busy cycle 10 -> mdu_busy drops immediately. After release, stay in RUN with no mdu_start unless a new op is present.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// branch flush, EXE/MEM-to-ID forwarding selects and multiply/divide unit scheduling.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [1:0]  id_mdu_op,
    input  logic        id_branch_taken,
    input  logic        exe_rf_we,
    input  logic [4:0]  exe_rf_waddr,
    input  logic        exe_is_load,
    input  logic        mem_rf_we,
    input  logic [4:0]  mem_rf_waddr,
    output logic        pc_we,
    output logic        iireg_we,
    output logic        iireg_flush,
    output logic        iereg_we,
    output logic        iereg_bubble,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic        mdu_start,
    output logic        mdu_is_div,
    output logic        mdu_busy,
    output logic [31:0] stall_count
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic rs_hit_exe;
    logic rt_hit_exe;
    logic rs_hit_mem;
    logic rt_hit_mem;
    logic load_use;
    logic mdu_hazard;
    logic stall;
    logic launch;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;

    // Register 0 is hard-wired zero, so a write to it never creates a dependency.
    assign rs_hit_exe = id_rs_used & exe_rf_we & (exe_rf_waddr != 5'd0) & (exe_rf_waddr == id_rs);
    assign rt_hit_exe = id_rt_used & exe_rf_we & (exe_rf_waddr != 5'd0) & (exe_rf_waddr == id_rt);
    assign rs_hit_mem = id_rs_used & mem_rf_we & (mem_rf_waddr != 5'd0) & (mem_rf_waddr == id_rs);
    assign rt_hit_mem = id_rt_used & mem_rf_we & (mem_rf_waddr != 5'd0) & (mem_rf_waddr == id_rt);

    assign load_use   = exe_is_load & (rs_hit_exe | rt_hit_exe);
    assign mdu_hazard = (state == BUSY) & (id_mdu_op != 2'b00);
    assign stall      = load_use | mdu_hazard;
    assign launch     = (state == RUN) & ~load_use & ((id_mdu_op == 2'b01) | (id_mdu_op == 2'b10));

    always_comb begin
        rs_sel = 2'b00;
        rt_sel = 2'b00;
        if (rs_hit_exe & ~exe_is_load) begin
            rs_sel = 2'b01;
        end else if (rs_hit_mem) begin
            rs_sel = 2'b10;
        end
        if (rt_hit_exe & ~exe_is_load) begin
            rt_sel = 2'b01;
        end else if (rt_hit_mem) begin
            rt_sel = 2'b10;
        end
    end

    // Every control is forced quiet while reset is held low.
    assign pc_we        = reset & ~stall;
    assign iireg_we     = reset & ~stall;
    assign iireg_flush  = reset & id_branch_taken & ~stall;
    assign iereg_we     = reset;
    assign iereg_bubble = reset & stall;
    assign fwd_rs_sel   = reset ? rs_sel : 2'b00;
    assign fwd_rt_sel   = reset ? rt_sel : 2'b00;
    assign mdu_start    = reset & launch;
    assign mdu_is_div   = reset & launch & (id_mdu_op == 2'b10);
    assign mdu_busy     = reset & (state == BUSY);

    // cnt holds the remaining busy cycles minus one; BUSY ends after the cycle where it reads zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (launch) begin
                    state_next = BUSY;
                    cnt_next   = (id_mdu_op == 2'b10) ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= 32'd0;
        end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule
